// File: rtl/mul_unit_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
package mul_unit_pkg;

  // Operation encoding as presented on the mul_op port.
  typedef enum logic [1:0] {
    MUL_LO  = 2'b00,
    MUL_HSS = 2'b01,
    MUL_HSU = 2'b10,
    MUL_HUU = 2'b11
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  localparam int MUL_WIDTH   = 32;
  // Edges from the accepting edge to the edge that raises done.
  localparam int MUL_LATENCY = MUL_WIDTH + 1;

  // rs1 is treated as signed for every op except MULHU.
  function automatic logic rs1_is_signed(input mul_op_t op);
    return (op != MUL_HUU);
  endfunction

  // rs2 is treated as signed only for MUL and MULH.
  function automatic logic rs2_is_signed(input mul_op_t op);
    return (op == MUL_LO) || (op == MUL_HSS);
  endfunction

endpackage

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are converted to sign + magnitude on acceptance, the unsigned
// magnitudes are multiplied over width cycles, and the sign is applied to
// the full 2*width product in the DONE cycle before selecting a half.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int width = 32,
  parameter int CNT_W = $clog2(width) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       mul_op,
  input  logic [width-1:0] rs1,
  input  logic [width-1:0] rs2_MUX,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] mul_out
);

  localparam int W2 = 2 * width;

  // Two's-complement negation of an operand; -MIN stays MIN, which is the
  // exact unsigned magnitude.
  function automatic logic [width-1:0] neg_w(input logic [width-1:0] x);
    return ~x + width'(1);
  endfunction

  // Two's-complement negation of the full product, wrap-around.
  function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] x);
    return ~x + W2'(1);
  endfunction

  mul_state_t       state;
  mul_op_t          op_q;
  logic             neg_q;
  logic [W2-1:0]    acc;
  logic [W2-1:0]    mcand;
  logic [width-1:0] mplier;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic [width-1:0] out_q;

  mul_op_t             op_in;
  logic signed [width-1:0] rs1_sgn;
  logic signed [width-1:0] rs2_sgn;
  logic                rs1_neg;
  logic                rs2_neg;
  logic [width-1:0]    mag1;
  logic [width-1:0]    mag2;
  logic [W2-1:0]       acc_nxt;
  logic [W2-1:0]       prod;
  logic [width-1:0]    res_sel;
  logic                last_iter;
  logic                accept;

  // Operand conditioning, next accumulator value and final result selection.
  always_comb begin
    op_in     = mul_op_t'(mul_op);
    rs1_sgn   = rs1;
    rs2_sgn   = rs2_MUX;
    rs1_neg   = rs1_is_signed(op_in) && (rs1_sgn < 0);
    rs2_neg   = rs2_is_signed(op_in) && (rs2_sgn < 0);
    mag1      = rs1_neg ? neg_w(rs1) : rs1;
    mag2      = rs2_neg ? neg_w(rs2_MUX) : rs2_MUX;
    acc_nxt   = mplier[0] ? (acc + mcand) : acc;
    prod      = neg_q ? neg_w2(acc) : acc;
    res_sel   = (op_q == MUL_LO) ? prod[width-1:0] : prod[W2-1:width];
    last_iter = (cnt == CNT_W'(width - 1));
    accept    = (state == IDLE) && start && !flush;
  end

  // Control FSM and shift-add datapath; done and mul_out are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= MUL_LO;
      neg_q  <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q   <= op_in;
            neg_q  <= rs1_neg ^ rs2_neg;
            acc    <= '0;
            mcand  <= {{width{1'b0}}, mag1};
            mplier <= mag2;
            cnt    <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (flush) begin
            // Abandon the operation; the accumulator is simply left stale.
            state <= IDLE;
          end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          // The result is already committed, so flush is not honoured here.
          out_q  <= res_sel;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = (state == BUSY);
  assign done    = done_q;
  assign mul_out = out_q;

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed vector table, multi-cycle
// corner sequences (flush, reset, start while busy) and random operations
// checked against a 64-bit arithmetic reference.
module tb_mul_unit;
  import mul_unit_pkg::*;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         flush;
  logic [1:0]   mul_op;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2_MUX;
  logic         busy;
  logic         done;
  logic [W-1:0] mul_out;

  int total;
  int bad;

  mul_unit #(.width(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .mul_op  (mul_op),
    .rs1     (rs1),
    .rs2_MUX (rs2_MUX),
    .busy    (busy),
    .done    (done),
    .mul_out (mul_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: extend each operand per its signedness and multiply in 64 bits.
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa;
    longint sb;
    longint p;
    logic [63:0] pu;
    sa = (op != 2'b11) ? longint'($signed(a)) : longint'({32'h0, a});
    sb = (op == 2'b00 || op == 2'b01) ? longint'($signed(b)) : longint'({32'h0, b});
    p  = sa * sb;
    pu = p;
    return (op == 2'b00) ? pu[31:0] : pu[63:32];
  endfunction

  // Issue one op, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input string nm, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] res,
                        output int lat, output int bcnt);
    int n;
    rs1 = a; rs2_MUX = b; mul_op = op; start = 1'b1;
    tick();
    start = 1'b0;
    rs1 = $urandom; rs2_MUX = $urandom; mul_op = 2'($urandom);
    check({nm, " busy_after_accept"}, {63'd0, busy}, 64'd1);
    check({nm, " done_low_after_accept"}, {63'd0, done}, 64'd0);
    n = 0;
    bcnt = busy ? 1 : 0;
    while (!done && n < 60) begin
      tick();
      n++;
      if (busy) bcnt++;
    end
    lat = n;
    res = mul_out;
    if (done) check({nm, " busy_low_at_done"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    vec_t         vecs[11];
    logic [W-1:0] res;
    logic [W-1:0] r2;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    int           lat;
    int           bcnt;
    int           ndone;
    logic [W-1:0] corner[5];

    total = 0;
    bad   = 0;

    vecs[0]  = '{2'b00, 32'h00000005, 32'h00000003, 32'h0000000F};
    vecs[1]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFA};
    vecs[2]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    vecs[3]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[4]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    vecs[5]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[7]  = '{2'b11, 32'h80000000, 32'h00000002, 32'h00000001};
    vecs[8]  = '{2'b10, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};
    vecs[9]  = '{2'b00, 32'h00000000, 32'h00012345, 32'h00000000};
    vecs[10] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF};

    corner[0] = 32'h00000000;
    corner[1] = 32'h00000001;
    corner[2] = 32'hFFFFFFFF;
    corner[3] = 32'h80000000;
    corner[4] = 32'h7FFFFFFF;

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; mul_op = 2'b00; rs1 = '0; rs2_MUX = '0;
    tick();
    tick();
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset mul_out", {32'd0, mul_out}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors, issued back-to-back on the done cycle.
    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcnt);
      check($sformatf("vec%0d result", i), {32'd0, res}, {32'd0, vecs[i].exp});
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(MUL_LATENCY));
      check($sformatf("vec%0d busy_cycles", i), 64'(bcnt), 64'(W));
    end

    // Flush mid-BUSY: no done pulse, mul_out keeps the previous result.
    run_op("pre_flush", 2'b00, 32'd5, 32'd3, res, lat, bcnt);
    check("pre_flush result", {32'd0, res}, 64'h0F);
    rs1 = 32'd7; rs2_MUX = 32'd9; mul_op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush busy_cleared", {63'd0, busy}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    check("flush no_done", 64'(ndone), 64'd0);
    check("flush mul_out_held", {32'd0, mul_out}, 64'h0F);
    run_op("after_flush", 2'b00, 32'd7, 32'd9, res, lat, bcnt);
    check("after_flush result", {32'd0, res}, 64'h3F);
    check("after_flush latency", 64'(lat), 64'(MUL_LATENCY));

    // start together with flush in IDLE is refused.
    tick();
    rs1 = 32'd2; rs2_MUX = 32'd2; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("start_flush not_accepted", {63'd0, busy}, 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) ndone++;
    end
    check("start_flush no_done", 64'(ndone), 64'd0);

    // Flush while in DONE still produces the done pulse.
    rs1 = 32'd6; rs2_MUX = 32'd7; mul_op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_in_done done", {63'd0, done}, 64'd1);
    check("flush_in_done result", {32'd0, mul_out}, 64'd42);

    // start pulsed during BUSY is ignored: exactly one done, original result.
    tick();
    rs1 = 32'd7; rs2_MUX = 32'd9; mul_op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    r2 = '0;
    for (int i = 0; i < 45; i++) begin
      if (i == 5) begin start = 1'b1; rs1 = 32'd3; rs2_MUX = 32'd3; end
      if (i == 8) start = 1'b0;
      tick();
      if (done) begin ndone++; r2 = mul_out; end
    end
    check("start_in_busy done_count", 64'(ndone), 64'd1);
    check("start_in_busy result", {32'd0, r2}, 64'h3F);

    // Asynchronous reset mid-BUSY clears outputs without waiting for an edge.
    rs1 = 32'd11; rs2_MUX = 32'd13; mul_op = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst busy", {63'd0, busy}, 64'd0);
    check("async_rst done", {63'd0, done}, 64'd0);
    check("async_rst mul_out", {32'd0, mul_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst idle", {63'd0, busy}, 64'd0);
    run_op("post_rst", 2'b00, 32'd11, 32'd13, res, lat, bcnt);
    check("post_rst result", {32'd0, res}, 64'd143);

    // Random operations, back-to-back, against the arithmetic reference.
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      run_op($sformatf("rnd%0d", i), op, a, b, res, lat, bcnt);
      check($sformatf("rnd%0d op%0d %h*%h", i, op, a, b), {32'd0, res}, {32'd0, model(op, a, b)});
      check($sformatf("rnd%0d latency", i), 64'(lat), 64'(MUL_LATENCY));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
